pass_monitor: RTL and testbench

//   Downstream consumer of the core's 'passed' result. Arms on 'start' and counts cycles.

---
 rtl/pass_monitor.sv | 95 +++++++++
 tb/tb_pass_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pass_monitor.sv
// pass_monitor: qualifies the core's passed flag over a timed run and reports a registered verdict
module pass_monitor #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT        = 1000,
  parameter int CONFIRM_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             passed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [7:0]       glitches
);
  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RUN, CONFIRM, PASS, FAIL} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CNT_W-1:0] cycles_n;
  logic [7:0]       glitches_n;
  logic             pass_n, fail_n, timeout_n;
  logic             run, hit, expire;
  always_comb begin
    run        = state == RUN || state == CONFIRM;
    hit        = passed && (state == RUN ? CONFIRM_CYCLES == 1 : cnt + CW'(1) == CW'(CONFIRM_CYCLES));
    expire     = cycles == CNT_W'(TIMEOUT - 1);
    state_n    = state;
    cnt_n      = cnt;
    cycles_n   = cycles;
    glitches_n = glitches;
    pass_n     = pass;
    fail_n     = fail;
    timeout_n  = timeout;
    if (run) begin
      cycles_n = cycles + CNT_W'(1);
      if (abort) begin
        state_n = FAIL;
        fail_n  = 1'b1;
      end else if (hit) begin
        state_n = PASS;
        pass_n  = 1'b1;
      end else begin
        // cnt is always 0 in RUN, so a first high sample lands at 1
        if (passed) begin
          state_n = CONFIRM;
          cnt_n   = cnt + CW'(1);
        end else begin
          state_n    = RUN;
          cnt_n      = '0;
          glitches_n = (state == CONFIRM && glitches != 8'hff) ? glitches + 8'd1 : glitches;
        end
        if (expire) begin
          state_n   = FAIL;
          fail_n    = 1'b1;
          timeout_n = 1'b1;
        end
      end
    end else if (start) begin
      state_n    = RUN;
      cnt_n      = '0;
      cycles_n   = '0;
      glitches_n = '0;
      pass_n     = 1'b0;
      fail_n     = 1'b0;
      timeout_n  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cycles   <= '0;
      glitches <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cycles   <= cycles_n;
      glitches <= glitches_n;
      pass     <= pass_n;
      fail     <= fail_n;
      timeout  <= timeout_n;
      busy     <= state_n == RUN || state_n == CONFIRM;
      done     <= state_n == PASS || state_n == FAIL;
    end
endmodule

// File: tb/tb_pass_monitor.sv
// tb_pass_monitor: three differently parameterised monitors checked every cycle against a run/streak model
module tb_pass_monitor;
  logic clk = 0, reset = 0;
  logic st[3], ab[3], ps[3];
  logic bz[3], dn[3], pa[3], fa[3], tm[3];
  logic [31:0] cy[3];
  logic [7:0] gl[3];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pass_monitor #(.CNT_W(32), .TIMEOUT(50), .CONFIRM_CYCLES(4)) u_a (
    .clk(clk), .reset(reset), .start(st[0]), .abort(ab[0]), .passed(ps[0]), .busy(bz[0]), .done(dn[0]),
    .pass(pa[0]), .fail(fa[0]), .timeout(tm[0]), .cycles(cy[0]), .glitches(gl[0]));
  pass_monitor #(.CNT_W(32), .TIMEOUT(1000), .CONFIRM_CYCLES(2)) u_b (
    .clk(clk), .reset(reset), .start(st[1]), .abort(ab[1]), .passed(ps[1]), .busy(bz[1]), .done(dn[1]),
    .pass(pa[1]), .fail(fa[1]), .timeout(tm[1]), .cycles(cy[1]), .glitches(gl[1]));
  pass_monitor #(.CNT_W(32), .TIMEOUT(10), .CONFIRM_CYCLES(1)) u_c (
    .clk(clk), .reset(reset), .start(st[2]), .abort(ab[2]), .passed(ps[2]), .busy(bz[2]), .done(dn[2]),
    .pass(pa[2]), .fail(fa[2]), .timeout(tm[2]), .cycles(cy[2]), .glitches(gl[2]));
  // ph: 0 idle, 1 running, 2 finished; str is the current run of high samples
  typedef struct packed {int ph; int cyc; int str; int gl; bit p; bit f; bit t;} m_t;
  m_t m[3];
  function automatic int to_of(int i);
    return i == 0 ? 50 : i == 1 ? 1000 : 10;
  endfunction
  function automatic int cc_of(int i);
    return i == 0 ? 4 : i == 1 ? 2 : 1;
  endfunction
  function automatic m_t step(m_t o, bit s, bit a, bit p, int to, int cc);
    m_t n = o;
    if (o.ph != 1) begin
      if (s) begin
        n = '0;
        n.ph = 1;
      end
    end else begin
      n.cyc = o.cyc + 1;
      if (a) begin
        n.ph = 2;
        n.f = 1;
      end else if (p && o.str + 1 >= cc) begin
        n.ph = 2;
        n.p = 1;
      end else begin
        if (p) n.str = o.str + 1;
        else begin
          if (o.str > 0 && o.gl < 255) n.gl = o.gl + 1;
          n.str = 0;
        end
        if (n.cyc == to) begin
          n.ph = 2;
          n.f = 1;
          n.t = 1;
        end
      end
    end
    return n;
  endfunction
  always @(posedge clk or negedge reset)
    for (int i = 0; i < 3; i++)
      m[i] = !reset ? '0 : step(m[i], st[i], ab[i], ps[i], to_of(i), cc_of(i));
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      logic [44:0] act, exp;
      act = {bz[i], dn[i], pa[i], fa[i], tm[i], cy[i], gl[i]};
      exp = {m[i].ph == 1, m[i].ph == 2, m[i].p, m[i].f, m[i].t, m[i].cyc[31:0], m[i].gl[7:0]};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL model dut%0d t=%0t got busy/done/pass/fail/tmo=%b cycles=%0d glitches=%0d want %b cycles=%0d glitches=%0d",
                 i, $time, act[44:40], act[39:8], act[7:0], exp[44:40], exp[39:8], exp[7:0]);
      end
    end
  task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  task automatic go(int i);
    st[i] = 1;
    @(negedge clk);
    st[i] = 0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; ab[i] = 0; ps[i] = 0;
    end
    repeat (2) @(negedge clk);
    lit("reset_busy", bz[0], 0);
    lit("reset_cycles", cy[0], 0);
    lit("reset_done", dn[1], 0);
    reset = 1;
    @(negedge clk);
    go(0);
    repeat (10) @(negedge clk);
    ps[0] = 1;
    repeat (3) @(negedge clk);
    lit("t1_pass_early", pa[0], 0);
    @(negedge clk);
    lit("t1_pass", pa[0], 1);
    lit("t1_done", dn[0], 1);
    lit("t1_cycles", cy[0], 14);
    lit("t1_glitches", gl[0], 0);
    ps[0] = 0;
    go(0);
    repeat (5) @(negedge clk);
    ps[0] = 1;
    repeat (2) @(negedge clk);
    ps[0] = 0;
    repeat (13) @(negedge clk);
    ps[0] = 1;
    repeat (3) @(negedge clk);
    lit("t2_pass_early", pa[0], 0);
    @(negedge clk);
    lit("t2_pass", pa[0], 1);
    lit("t2_glitches", gl[0], 1);
    ps[0] = 0;
    go(0);
    repeat (49) @(negedge clk);
    lit("t3_busy_before", bz[0], 1);
    @(negedge clk);
    lit("t3_fail", fa[0], 1);
    lit("t3_timeout", tm[0], 1);
    lit("t3_cycles", cy[0], 50);
    lit("t3_busy", bz[0], 0);
    go(0);
    repeat (5) @(negedge clk);
    ps[0] = 1;
    repeat (2) @(negedge clk);
    ab[0] = 1;
    @(negedge clk);
    ab[0] = 0;
    ps[0] = 0;
    repeat (3) @(negedge clk);
    lit("t4_fail", fa[0], 1);
    lit("t4_timeout", tm[0], 0);
    lit("t4_cycles", cy[0], 8);
    go(0);
    lit("t4_rearm_fail", fa[0], 0);
    lit("t4_rearm_cycles", cy[0], 0);
    lit("t4_rearm_busy", bz[0], 1);
    ps[0] = 1;
    repeat (2) @(negedge clk);
    #2 reset = 0;
    #1;
    lit("t5_busy", bz[0], 0);
    lit("t5_cycles", cy[0], 0);
    lit("t5_fail", fa[0], 0);
    @(negedge clk);
    reset = 1;
    ps[0] = 0;
    go(0);
    repeat (3) @(negedge clk);
    go(0);
    lit("t5_start_busy", cy[0], 4);
    go(2);
    repeat (9) @(negedge clk);
    ps[2] = 1;
    @(negedge clk);
    ps[2] = 0;
    lit("t6_pass", pa[2], 1);
    lit("t6_timeout", tm[2], 0);
    lit("t6_cycles", cy[2], 10);
    go(1);
    for (int k = 0; k < 300; k++) begin
      ps[1] = 1;
      @(negedge clk);
      ps[1] = 0;
      @(negedge clk);
    end
    lit("sat_glitches", gl[1], 255);
    lit("sat_busy", bz[1], 1);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        st[i] = $urandom_range(0, 19) == 0;
        ab[i] = $urandom_range(0, 59) == 0;
        if ($urandom_range(0, 3) == 0) ps[i] = !ps[i];
      end
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
